// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit to each frame).
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 104;

    // Transmitter FSM states; PARITY exists only when the parity bit is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        FETCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
// 'clear' restarts the period so every FSM state change begins on a fresh bit boundary.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Free-running period counter, wrapping after the last cycle or restarting on clear/reset.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a byte FIFO and sends 8N1 frames, LSB first.
// Optional feature macro: UART_TX_PARITY_EN (inserts an even-parity bit before the stop bit).
// All outputs are registered; tx lags the FSM state by one cycle, so the line falls three
// edges after a non-empty FIFO is seen in IDLE, and IDLE/POP/FETCH stretch the stop bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bitIdx_q;
    logic                 tx_q;
    logic                 pop_q;
    logic                 busy_q;
    logic                 bitDone;
    logic                 clearCnt;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    // Every state change restarts the bit period so each bit gets a full CLKS_PER_BIT cycles.
    assign clearCnt = (state_d != state_q);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (clearCnt),
        .bit_done(bitDone)
    );

    // Next-state decision; fifo_empty only matters while waiting in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_d = POP;
            POP:   state_d = FETCH;
            FETCH: state_d = START;
            START: if (bitDone) state_d = DATA;
            DATA: begin
                if (bitDone && (bitIdx_q == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bitDone) state_d = STOP;
`endif
            STOP:  if (bitDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            pop_q    <= 1'b0;
            busy_q   <= 1'b0;
            shift_q  <= '0;
            bitIdx_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pop_q   <= (state_d == POP);
            busy_q  <= (state_d != IDLE) || (state_q != IDLE);

            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  tx_q <= parity_q;
`endif
                default: tx_q <= 1'b1;
            endcase

            if (state_q == FETCH) begin
                shift_q  <= fifo_data;
                bitIdx_q <= '0;
`ifdef UART_TX_PARITY_EN
                parity_q <= ^fifo_data;
`endif
            end else if ((state_q == DATA) && bitDone) begin
                shift_q  <= shift_q >> 1;
                bitIdx_q <= bitIdx_q + 3'(1);
            end
        end
    end

    assign fifo_pop = pop_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4.
// A queue-based byte FIFO feeds the DUT; expected tx/busy/pop waveforms are computed
// arithmetically from the frame layout (3 setup cycles, then start, data, [parity], stop).
module tb_fifo_uart_tx;

    localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int PERIOD = 3 + CLKS * FRAME_BITS;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       fifoPop;
    logic       tx;
    logic       busy;

    int         checkCount     = 0;
    int         failCount      = 0;
    int         popCount       = 0;
    int         underflowCount = 0;
    logic [7:0] byteQ[$];
    logic [7:0] expQ[$];
    bit         toggleMode = 1'b0;
    bit         toggleVal  = 1'b0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifoEmpty),
        .fifo_data (fifoData),
        .fifo_pop  (fifoPop),
        .tx        (tx),
        .busy      (busy)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic updateEmpty();
        fifoEmpty = toggleMode ? toggleVal : (byteQ.size() == 0);
    endtask

    // Advance one cycle to the falling edge and let the FIFO model service a pop.
    task automatic tick();
        @(negedge clk);
        if (fifoPop === 1'b1) begin
            popCount++;
            if (byteQ.size() == 0) underflowCount++;
            else fifoData = byteQ.pop_front();
        end
        updateEmpty();
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        byteQ.push_back(b);
        expQ.push_back(b);
        updateEmpty();
    endtask

    // Expected line level t cycles after the first edge that sees a non-empty FIFO.
    function automatic logic expTx(input int t);
        int k;
        int r;
        int pos;
        logic [7:0] b;
        k = t / PERIOD;
        r = t % PERIOD;
        if (k >= expQ.size()) return 1'b1;
        if (r < 3) return 1'b1;
        pos = (r - 3) / CLKS;
        b = expQ[k];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Follow all queued frames cycle by cycle against the model, optionally toggling fifo_empty mid-frame.
    task automatic checkFrames(input bit doToggle);
        int n;
        int total;
        int busyCycles;
        int popStart;
        n = expQ.size();
        total = n * PERIOD + 8;
        busyCycles = 0;
        popStart = popCount;
        for (int t = 0; t < total; t++) begin
            tick();
            checkOutput($sformatf("tx@%0d", t), tx, expTx(t));
            checkOutput($sformatf("busy@%0d", t), busy, (t < n * PERIOD));
            checkOutput($sformatf("pop@%0d", t), fifoPop, ((t < n * PERIOD) && (t % PERIOD == 0)));
            if (busy === 1'b1) busyCycles++;
            if (doToggle && (t < n * PERIOD) && (t % PERIOD >= 6) && (t % PERIOD < PERIOD - 6)) begin
                toggleMode = 1'b1;
                toggleVal  = ~toggleVal;
            end else begin
                toggleMode = 1'b0;
            end
            updateEmpty();
        end
        checkOutput("busyCycles", busyCycles, n * PERIOD);
        checkOutput("framePops", popCount - popStart, n);
        expQ.delete();
    endtask

    initial begin
        reset      = 1'b1;
        fifoData   = 8'h00;
        toggleMode = 1'b1;
        toggleVal  = 1'b0;
        updateEmpty();

        // Reset held with a non-empty FIFO: line idle, no pop, not busy.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("resetTx", tx, 1'b1);
            checkOutput("resetBusy", busy, 1'b0);
            checkOutput("resetPop", fifoPop, 1'b0);
        end
        reset      = 1'b0;
        toggleMode = 1'b0;
        updateEmpty();

        // Empty FIFO for 100 cycles: nothing happens.
        for (int i = 0; i < 100; i++) begin
            tick();
            checkOutput("idleTx", tx, 1'b1);
            checkOutput("idlePop", fifoPop, 1'b0);
            checkOutput("idleBusy", busy, 1'b0);
        end

        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5);
        checkFrames(1'b0);

        $display("[TB] back-to-back 0x00, 0xFF");
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        checkFrames(1'b0);

        $display("[TB] parity patterns 0x07 and 0x03");
        applyStimulus(8'h07);
        checkFrames(1'b0);
        applyStimulus(8'h03);
        checkFrames(1'b0);

        $display("[TB] fifo_empty toggling mid-frame");
        applyStimulus(8'h96);
        checkFrames(1'b1);

        $display("[TB] reset during data bit 3 of 0x3C");
        applyStimulus(8'h3C);
        applyStimulus(8'h5A);
        for (int t = 0; t <= 20; t++) begin
            tick();
            checkOutput($sformatf("preResetTx@%0d", t), tx, expTx(t));
        end
        reset = 1'b1;
        tick();
        checkOutput("abortTx", tx, 1'b1);
        checkOutput("abortBusy", busy, 1'b0);
        checkOutput("abortPop", fifoPop, 1'b0);
        tick();
        checkOutput("abortPopHeld", fifoPop, 1'b0);
        reset = 1'b0;
        expQ.delete();
        expQ.push_back(8'h5A);
        checkFrames(1'b0);
        checkOutput("queueDrained", byteQ.size(), 0);

        $display("[TB] randomized bursts");
        for (int iter = 0; iter < 8; iter++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) applyStimulus(8'($urandom_range(0, 255)));
            checkFrames(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) tick();
        end

        checkOutput("underflow", underflowCount, 0);
        checkOutput("totalPops", popCount, 20 - 20 + popCount - byteQ.size());

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
